vga_sync: RTL and testbench

// - VGA timing generator; sits directly downstream of the clock divider and

---
 rtl/vga_sync.sv | 63 ++++++
 tb/tb_vga_sync.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/vga_sync.sv
// vga_sync: VGA timing generator advancing h/v counters on each pixel enable tick,
// producing registered active-low syncs, video_on, pixel coordinates and a frame-start pulse.
module vga_sync #(
  parameter int HD  = 640,
  parameter int HFP = 16,
  parameter int HSW = 96,
  parameter int HBP = 48,
  parameter int VD  = 480,
  parameter int VFP = 10,
  parameter int VSW = 2,
  parameter int VBP = 33
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pix_tick,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       frame_start
);
  localparam logic [9:0] H_MAX = 10'(HD + HFP + HSW + HBP - 1);
  localparam logic [9:0] V_MAX = 10'(VD + VFP + VSW + VBP - 1);
  localparam logic [9:0] H_DSP = 10'(HD);
  localparam logic [9:0] V_DSP = 10'(VD);
  localparam logic [9:0] HS_LO = 10'(HD + HFP);
  localparam logic [9:0] HS_HI = 10'(HD + HFP + HSW - 1);
  localparam logic [9:0] VS_LO = 10'(VD + VFP);
  localparam logic [9:0] VS_HI = 10'(VD + VFP + VSW - 1);
  logic [9:0] h_q, h_d, v_q, v_d;
  logic       hs_q, hs_d, vs_q, vs_d, fs_q, fs_d, h_end;
  // Syncs decode the next counts so they switch on the same edge as the counters.
  always_comb begin
    h_end = h_q == H_MAX;
    h_d   = pix_tick ? (h_end ? 10'd0 : h_q + 10'd1) : h_q;
    v_d   = (pix_tick && h_end) ? ((v_q == V_MAX) ? 10'd0 : v_q + 10'd1) : v_q;
    hs_d  = !(h_d >= HS_LO && h_d <= HS_HI);
    vs_d  = !(v_d >= VS_LO && v_d <= VS_HI);
    fs_d  = pix_tick && h_end && (v_q == V_MAX);
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      h_q  <= '0;
      v_q  <= '0;
      hs_q <= 1'b1;
      vs_q <= 1'b1;
      fs_q <= 1'b0;
    end else begin
      h_q  <= h_d;
      v_q  <= v_d;
      hs_q <= hs_d;
      vs_q <= vs_d;
      fs_q <= fs_d;
    end
  end
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign frame_start = fs_q;
  assign pixel_x     = h_q;
  assign pixel_y     = v_q;
  assign video_on    = (h_q < H_DSP) && (v_q < V_DSP);
endmodule

// File: tb/tb_vga_sync.sv
// tb_vga_sync: directed checks of vga_sync; full-size instance for line timing, a
// shrunken instance (15x8 frame) for vertical sync, frame_start and mid-sync reset.
module tb_vga_sync;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pix_tick = 1'b0;
  logic       hsync, vsync, video_on, frame_start;
  logic [9:0] pixel_x, pixel_y;
  logic       s_hsync, s_vsync, s_video_on, s_frame_start;
  logic [9:0] s_x, s_y;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  vga_sync dut (
    .clk(clk), .reset(reset), .pix_tick(pix_tick), .hsync(hsync), .vsync(vsync),
    .video_on(video_on), .pixel_x(pixel_x), .pixel_y(pixel_y), .frame_start(frame_start)
  );

  // Small frame: H_TOT=15 (hsync low h=10..12), V_TOT=8 (vsync low v=5..6), display 8x4.
  vga_sync #(.HD(8), .HFP(2), .HSW(3), .HBP(2), .VD(4), .VFP(1), .VSW(2), .VBP(1)) sdut (
    .clk(clk), .reset(reset), .pix_tick(pix_tick), .hsync(s_hsync), .vsync(s_vsync),
    .video_on(s_video_on), .pixel_x(s_x), .pixel_y(s_y), .frame_start(s_frame_start)
  );

  task automatic step(input logic t);
    pix_tick = t;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) step(i[0]);
    reset = 1'b1;
    pix_tick = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (hsync !== 1'b1) begin bad++; $display("FAIL reset_hsync got=%b exp=1", hsync); end
    total++; if (vsync !== 1'b1) begin bad++; $display("FAIL reset_vsync got=%b exp=1", vsync); end
    total++; if (pixel_x !== 10'd0) begin bad++; $display("FAIL reset_x got=%0d exp=0", pixel_x); end
    total++; if (pixel_y !== 10'd0) begin bad++; $display("FAIL reset_y got=%0d exp=0", pixel_y); end
    total++; if (video_on !== 1'b1) begin bad++; $display("FAIL reset_video_on got=%b exp=1", video_on); end
    total++; if (frame_start !== 1'b0) begin bad++; $display("FAIL reset_fs got=%b exp=0", frame_start); end
  endtask

  task automatic test_line_wrap();
    logic seen_fs = 1'b0;
    do_reset();
    for (int i = 0; i < 799; i++) begin
      step(1'b1);
      seen_fs |= frame_start;
    end
    total++; if (pixel_x !== 10'd799) begin bad++; $display("FAIL wrap_pre_x got=%0d exp=799", pixel_x); end
    total++; if (pixel_y !== 10'd0) begin bad++; $display("FAIL wrap_pre_y got=%0d exp=0", pixel_y); end
    step(1'b1);
    seen_fs |= frame_start;
    total++; if (pixel_x !== 10'd0) begin bad++; $display("FAIL wrap_x got=%0d exp=0", pixel_x); end
    total++; if (pixel_y !== 10'd1) begin bad++; $display("FAIL wrap_y got=%0d exp=1", pixel_y); end
    total++; if (seen_fs !== 1'b0) begin bad++; $display("FAIL wrap_no_fs got=%b exp=0", seen_fs); end
  endtask

  task automatic test_line_scan();
    int hs_low = 0;
    int errs = 0;
    do_reset();
    for (int k = 1; k <= 800; k++) begin
      step(1'b1);
      if (k < 800) begin
        if (pixel_x !== 10'(k) || hsync !== !(k >= 656 && k <= 751) || video_on !== (k < 640)) begin
          errs++;
          if (errs < 5) $display("FAIL scan k=%0d got x=%0d hs=%b von=%b", k, pixel_x, hsync, video_on);
        end
      end
      if (hsync === 1'b0) hs_low++;
    end
    total++; if (errs != 0) begin bad++; $display("FAIL scan_errs got=%0d exp=0", errs); end
    total++; if (hs_low != 96) begin bad++; $display("FAIL scan_hs_low got=%0d exp=96", hs_low); end
  endtask

  task automatic test_freeze();
    int errs = 0;
    do_reset();
    for (int i = 0; i < 655; i++) step(1'b1);
    total++; if (pixel_x !== 10'd655) begin bad++; $display("FAIL freeze_start_x got=%0d exp=655", pixel_x); end
    for (int i = 0; i < 37; i++) begin
      step(1'b0);
      if (pixel_x !== 10'd655 || pixel_y !== 10'd0 || hsync !== 1'b1 || vsync !== 1'b1 ||
          video_on !== 1'b0 || frame_start !== 1'b0) errs++;
    end
    total++; if (errs != 0) begin bad++; $display("FAIL freeze_hold got=%0d errs exp=0", errs); end
    step(1'b1);
    total++; if (pixel_x !== 10'd656) begin bad++; $display("FAIL freeze_next_x got=%0d exp=656", pixel_x); end
    total++; if (hsync !== 1'b0) begin bad++; $display("FAIL freeze_next_hs got=%b exp=0", hsync); end
  endtask

  task automatic test_divided_tick();
    do_reset();
    for (int i = 0; i < 20; i++) step(i[0]);
    total++; if (pixel_x !== 10'd10) begin bad++; $display("FAIL div_tick_x got=%0d exp=10", pixel_x); end
  endtask

  task automatic test_reset_mid_hsync();
    do_reset();
    for (int i = 0; i < 700; i++) step(1'b1);
    total++; if (hsync !== 1'b0) begin bad++; $display("FAIL midh_hs got=%b exp=0", hsync); end
    reset = 1'b0;
    step(1'b1);
    reset = 1'b1;
    total++; if (hsync !== 1'b1 || pixel_x !== 10'd0) begin bad++; $display("FAIL midh_rst got hs=%b x=%0d exp hs=1 x=0", hsync, pixel_x); end
  endtask

  task automatic test_frame();
    int errs = 0;
    int vs_low = 0;
    int fs_cnt = 0;
    int x, y;
    do_reset();
    for (int n = 1; n <= 240; n++) begin
      step(1'b1);
      x = n % 15;
      y = (n / 15) % 8;
      if (s_x !== 10'(x) || s_y !== 10'(y) || s_hsync !== !(x >= 10 && x <= 12) ||
          s_vsync !== !(y >= 5 && y <= 6) || s_video_on !== (x < 8 && y < 4) ||
          s_frame_start !== (n % 120 == 0)) begin
        errs++;
        if (errs < 5) $display("FAIL frame n=%0d got x=%0d y=%0d hs=%b vs=%b fs=%b", n, s_x, s_y, s_hsync, s_vsync, s_frame_start);
      end
      if (s_vsync === 1'b0) vs_low++;
      if (s_frame_start === 1'b1) begin
        fs_cnt++;
        step(1'b0);
        total++; if (s_frame_start !== 1'b0) begin bad++; $display("FAIL fs_width got=%b exp=0", s_frame_start); end
      end
    end
    total++; if (errs != 0) begin bad++; $display("FAIL frame_errs got=%0d exp=0", errs); end
    total++; if (vs_low != 60) begin bad++; $display("FAIL frame_vs_low got=%0d exp=60", vs_low); end
    total++; if (fs_cnt != 2) begin bad++; $display("FAIL frame_fs_cnt got=%0d exp=2", fs_cnt); end
  endtask

  task automatic test_reset_mid_sync();
    do_reset();
    for (int i = 0; i < 101; i++) step(1'b1);
    total++; if (s_x !== 10'd11 || s_y !== 10'd6) begin bad++; $display("FAIL mids_pos got=(%0d,%0d) exp=(11,6)", s_x, s_y); end
    total++; if (s_hsync !== 1'b0 || s_vsync !== 1'b0) begin bad++; $display("FAIL mids_sync got hs=%b vs=%b exp=0 0", s_hsync, s_vsync); end
    reset = 1'b0;
    step(1'b1);
    reset = 1'b1;
    total++; if (s_hsync !== 1'b1 || s_vsync !== 1'b1) begin bad++; $display("FAIL mids_rst_sync got hs=%b vs=%b exp=1 1", s_hsync, s_vsync); end
    total++; if (s_x !== 10'd0 || s_y !== 10'd0 || s_frame_start !== 1'b0) begin bad++; $display("FAIL mids_rst_pos got=(%0d,%0d) fs=%b exp=(0,0) 0", s_x, s_y, s_frame_start); end
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_line_wrap();
    test_line_scan();
    test_freeze();
    test_divided_tick();
    test_reset_mid_hsync();
    test_frame();
    test_reset_mid_sync();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
